// File: rtl/dft_crm_div_ctrl_if.sv
// Config handshake between the CRM config registers and the divider controller.
interface dft_crm_div_ctrl_if #(
  parameter int DW = 4
);
  logic          cfg_req;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_high;
  logic          cfg_ack;
  logic          cfg_err;

  modport master (
    output cfg_req, cfg_div, cfg_high,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_req, cfg_div, cfg_high,
    output cfg_ack, cfg_err
  );
endinterface

// File: rtl/dft_crm_div_ctrl.sv
// Runtime ratio/duty controller for the CRM divider: glitch-free ratio changes
// applied at a period boundary after a forced-low gap, with DFT freeze/reject.
module dft_crm_div_ctrl #(
  parameter int DW       = 4,
  parameter int DEF_DIV  = 3,
  parameter int DEF_HIGH = 2,
  parameter int GATE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n_mux,
  input  logic                     test_mode,
  input  logic                     test_se,
  dft_crm_div_ctrl_if.slave        cfg,
  output logic                     busy,
  output logic                     clko,
  output logic [DW-1:0]            cur_div,
  output logic [DW-1:0]            cur_high
);

  localparam int GW = $clog2(GATE_CYC + 1);

  typedef enum logic [1:0] {RUN, WAIT_END, GATE, DRAIN} state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] pend_div;
  logic [DW-1:0] pend_high;
  logic [GW-1:0] gcnt;

  logic [DW-1:0] div_m1;
  logic [DW-1:0] cnt_nxt;
  logic          wrap;
  logic          legal;
  logic          freeze;

  assign div_m1  = cur_div - DW'(1);
  assign wrap    = (cnt == div_m1);
  assign cnt_nxt = wrap ? '0 : cnt + DW'(1);
  assign legal   = (cfg.cfg_div >= DW'(2)) && (cfg.cfg_high >= DW'(1)) &&
                   (cfg.cfg_high <= cfg.cfg_div - DW'(1));
  assign freeze  = test_mode & test_se;

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      state       <= RUN;
      cnt         <= '0;
      clko        <= 1'b0;
      gcnt        <= '0;
      busy        <= 1'b0;
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      cur_div     <= DW'(DEF_DIV);
      cur_high    <= DW'(DEF_HIGH);
      pend_div    <= DW'(DEF_DIV);
      pend_high   <= DW'(DEF_HIGH);
    end else if (!freeze) begin
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      cnt         <= cnt_nxt;
      clko        <= (cnt_nxt < cur_high);
      case (state)
        RUN: begin
          if (cfg.cfg_req) begin
            if (!legal || test_mode) begin
              cfg.cfg_ack <= 1'b1;
              cfg.cfg_err <= 1'b1;
              state       <= DRAIN;
            end else begin
              pend_div  <= cfg.cfg_div;
              pend_high <= cfg.cfg_high;
              busy      <= 1'b1;
              state     <= WAIT_END;
            end
          end
        end
        WAIT_END: begin
          if (test_mode) begin
            cfg.cfg_ack <= 1'b1;
            cfg.cfg_err <= 1'b1;
            busy        <= 1'b0;
            state       <= DRAIN;
          end else if (wrap) begin
            cur_div  <= pend_div;
            cur_high <= pend_high;
            cnt      <= '0;
            clko     <= 1'b0;
            gcnt     <= '0;
            state    <= GATE;
          end
        end
        GATE: begin
          clko <= 1'b0;
          // Park cnt at the last count so the cycle after the ack starts a fresh period high.
          if (gcnt == GW'(GATE_CYC - 1)) begin
            cnt         <= div_m1;
            cfg.cfg_ack <= 1'b1;
            busy        <= 1'b0;
            state       <= DRAIN;
          end else begin
            cnt  <= '0;
            gcnt <= gcnt + GW'(1);
          end
        end
        DRAIN: begin
          if (!cfg.cfg_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_crm_div_ctrl.sv
// Randomized bench for dft_crm_div_ctrl against a time-origin waveform model.
module tb_dft_crm_div_ctrl;
  localparam int DW       = 4;
  localparam int DEF_DIV  = 3;
  localparam int DEF_HIGH = 2;
  localparam int GATE_CYC = 2;
  localparam int FRZ      = 10;

  logic          clk = 1'b0;
  logic          rst_n_mux = 1'b0;
  logic          test_mode = 1'b0;
  logic          test_se = 1'b0;
  logic          busy;
  logic          clko;
  logic [DW-1:0] cur_div;
  logic [DW-1:0] cur_high;

  dft_crm_div_ctrl_if #(.DW(DW)) cfg();

  dft_crm_div_ctrl #(
    .DW(DW), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH), .GATE_CYC(GATE_CYC)
  ) dut (
    .clk(clk),
    .rst_n_mux(rst_n_mux),
    .test_mode(test_mode),
    .test_se(test_se),
    .cfg(cfg),
    .busy(busy),
    .clko(clko),
    .cur_div(cur_div),
    .cur_high(cur_high)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Waveform model: index 1 is the setting in force from cycle sw on, index 0 before it.
  // clko(n) = ((n - t0) mod div) < high, except inside the forced-low window.
  int w_t0[2];
  int w_div[2];
  int w_high[2];
  int sw      = 0;
  int gap_lo  = 0;
  int gap_hi  = -1;
  int ack_cyc = -1;
  int busy_lo = 0;
  int busy_hi = -1;
  bit ack_err = 1'b0;
  bit mon_en  = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int sel(input int n);
    return (n < sw) ? 0 : 1;
  endfunction

  function automatic int exp_clko(input int n);
    int k;
    k = sel(n);
    if (n >= gap_lo && n <= gap_hi) return 0;
    return (((n - w_t0[k]) % w_div[k]) < w_high[k]) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("clko", clko, exp_clko(cyc));
      chk("cur_div", cur_div, w_div[sel(cyc)]);
      chk("cur_high", cur_high, w_high[sel(cyc)]);
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      chk("ack", cfg.cfg_ack, (cyc == ack_cyc) ? 1 : 0);
      if (cyc == ack_cyc) chk("err", cfg.cfg_err, ack_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; reset is released the same way len cycles later.
  task automatic apply_reset(input int len);
    int a;
    a = cyc;
    rst_n_mux   = 1'b0;
    cfg.cfg_req = 1'b0;
    test_mode   = 1'b0;
    test_se     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_div[i]  = DEF_DIV;
      w_high[i] = DEF_HIGH;
      w_t0[i]   = a + len;
    end
    sw      = 0;
    gap_lo  = a;
    gap_hi  = a + len;
    ack_cyc = -1;
    if (busy_hi >= a) busy_hi = a - 1;
    mon_en  = 1'b1;
    repeat (len) step();
    rst_n_mux = 1'b1;
  endtask

  task automatic wait_pos0();
    int t;
    t = 0;
    while (((cyc - w_t0[1]) % w_div[1]) != 0 && t < 40) begin
      step();
      t++;
    end
  endtask

  // mode: 0 plain, 1 abort via test_mode in WAIT_END, 2 scan freeze in GATE,
  // 3 reset in GATE, 4 hold cfg_req after the ack.
  task automatic do_req(input int d, input int h, input int mode);
    int n, p1, n_end, t;
    bit rej;
    n   = cyc;
    rej = test_mode || !(d >= 2 && h >= 1 && h < d);
    cfg.cfg_div  = DW'(d);
    cfg.cfg_high = DW'(h);
    cfg.cfg_req  = 1'b1;
    n_end = n;
    if (rej) begin
      ack_cyc = n + 1;
      ack_err = 1'b1;
      busy_lo = 0;
      busy_hi = -1;
    end else begin
      p1      = (n + 1 - w_t0[1]) % w_div[1];
      n_end   = n + 1 + (w_div[1] - 1 - p1);
      busy_lo = n + 1;
      if (mode == 1) begin
        ack_cyc = n + 2;
        ack_err = 1'b1;
        busy_hi = n + 1;
        step();
        test_mode = 1'b1;
      end else begin
        w_t0[0]   = w_t0[1];
        w_div[0]  = w_div[1];
        w_high[0] = w_high[1];
        sw        = n_end + 1;
        w_div[1]  = d;
        w_high[1] = h;
        gap_lo    = n_end + 1;
        gap_hi    = n_end + GATE_CYC + 1;
        w_t0[1]   = n_end + GATE_CYC + 2;
        ack_cyc   = n_end + GATE_CYC + 1;
        ack_err   = 1'b0;
        busy_hi   = n_end + GATE_CYC;
      end
    end
    if (!rej && (mode == 2 || mode == 3)) begin
      while (cyc < n_end + 1) step();
      if (mode == 3) begin
        apply_reset(2);
        chk("rst_cur_div", cur_div, DEF_DIV);
        return;
      end
      test_mode = 1'b1;
      test_se   = 1'b1;
      gap_hi   += FRZ;
      w_t0[1]  += FRZ;
      ack_cyc  += FRZ;
      busy_hi  += FRZ;
      repeat (FRZ) step();
      test_mode = 1'b0;
      test_se   = 1'b0;
    end
    t = 0;
    do begin
      step();
      t++;
    end while (!cfg.cfg_ack && t < 300);
    chk("ack_seen", cfg.cfg_ack, 1);
    chk("ack_cycle", cyc, ack_cyc);
    if (!rej && mode == 1) begin
      test_mode = 1'b0;
      chk("abort_cur_div", cur_div, w_div[1]);
    end
    if (mode == 4) repeat (8) step();
    cfg.cfg_req = 1'b0;
    step();
  endtask

  initial begin
    int d, h, r, mode;
    w_div[0] = DEF_DIV; w_div[1] = DEF_DIV;
    w_high[0] = DEF_HIGH; w_high[1] = DEF_HIGH;
    w_t0[0] = 0; w_t0[1] = 0;
    cfg.cfg_req  = 1'b0;
    cfg.cfg_div  = '0;
    cfg.cfg_high = '0;
    step();
    apply_reset(3);
    chk("reset_cur_div", cur_div, DEF_DIV);
    chk("reset_cur_high", cur_high, DEF_HIGH);
    repeat (7) step();

    wait_pos0(); step();
    do_req(5, 2, 0);
    repeat (12) step();

    do_req(1, 1, 0); step();
    do_req(4, 4, 0); step();
    do_req(0, 3, 0); step();

    apply_reset(2);
    step();
    test_mode = 1'b1;
    do_req(6, 3, 0);
    test_mode = 1'b0;
    step();
    wait_pos0();
    do_req(6, 3, 1);
    repeat (4) step();

    do_req(7, 3, 2);
    repeat (5) step();
    do_req(9, 4, 3);
    repeat (4) step();
    do_req(4, 1, 4);
    repeat (3) step();
    do_req(15, 14, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) step();
      if ($urandom_range(0, 2) != 0) begin
        d = $urandom_range(2, 15);
        h = $urandom_range(1, d - 1);
      end else begin
        d = $urandom_range(0, 15);
        h = $urandom_range(0, 15);
      end
      r = $urandom_range(0, 9);
      mode = (r < 5) ? 0 : (r < 7) ? 4 : (r == 7) ? 2 : (r == 8) ? 1 : 3;
      if (mode == 1) begin
        if (w_div[1] >= 3) wait_pos0();
        else mode = 0;
      end
      if ($urandom_range(0, 7) == 0) begin
        test_mode = 1'b1;
        do_req(d, h, 0);
        test_mode = 1'b0;
      end else begin
        do_req(d, h, mode);
      end
    end
    repeat (6) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
